// File: rtl/regfile_mp.sv
// Integer register file: NREAD combinational read ports with write bypass,
// one write port, per-entry pending scoreboard and a one-entry-per-cycle clear engine.
//
// state | meaning
// IDLE  | normal operation, clr_start accepted
// CLEAR | zeroing entry r_idx each cycle; writes and issues ignored
// DONE  | clear finished, clr_done pulses for this cycle
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_pend,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_rd,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_pend;
  logic [AW-1:0]    r_idx;
  logic             w_busy;
  logic             w_we_eff;
  logic             w_iss_eff;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (clr_start) w_state_nxt = S_CLEAR;
      S_CLEAR: if (r_idx == AW'(NREGS - 1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = 1'b0;
    clr_done = 1'b0;
    case (r_state)
      S_CLEAR: w_busy   = 1'b1;
      S_DONE:  clr_done = 1'b1;
      default: ;
    endcase
  end

  assign clr_busy  = w_busy;
  assign w_we_eff  = we && (waddr != '0) && !w_busy;
  assign w_iss_eff = iss_en && (iss_rd != '0) && !w_busy;

  // Issue is applied after the write so a same-entry issue+write leaves it pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_pend <= '0;
      r_idx  <= '0;
    end else begin
      if (r_state == S_CLEAR) begin
        r_regs[r_idx] <= '0;
        r_pend[r_idx] <= 1'b0;
        r_idx         <= r_idx + AW'(1);
      end else if (r_state == S_IDLE && clr_start) begin
        r_idx <= AW'(1);
      end
      if (w_we_eff) begin
        r_regs[waddr] <= wdata;
        r_pend[waddr] <= 1'b0;
      end
      if (w_iss_eff) r_pend[iss_rd] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_hit;
    assign w_addr = rd_addr[k*AW +: AW];
    assign w_hit  = w_we_eff && (waddr == w_addr);
    assign rd_data[k*XLEN +: XLEN] = (w_addr == '0) ? '0 : (w_hit ? wdata : r_regs[w_addr]);
    assign rd_pend[k] = r_pend[w_addr] && !w_hit && !w_busy;
  end

endmodule
